// File: rtl/sign_restore_pkg.sv
// sign_restore_pkg: shared state encoding, default width and counter sizing helper
package sign_restore_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int DEFAULT_WIDTH = 16;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sign_restore_bit.sv
// bit_counter: rollover counter with clear; rollover_flag marks the last bit position
module bit_counter
    import sign_restore_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CW = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          count_enable,
    output logic [CW-1:0] count,
    output logic          rollover_flag
);

    assign rollover_flag = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (count_enable)
            count <= rollover_flag ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/sign_restore.sv
// sign_restore: serial sign-magnitude to two's-complement converter, LSB first,
// one bit per clock, (WIDTH+1)-bit result with a one-cycle valid pulse.
module sign_restore
    import sign_restore_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             sign,
    input  logic [WIDTH-1:0] mag,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH:0]   result,
    output logic             overrun
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mag_q, sh;
    logic             sign_q, seen;
    logic [CW-1:0]    cnt;
    logic             last, accept, in_bit, out_bit;

    assign accept  = load && (state != SHIFT);
    assign in_bit  = mag_q[cnt];
    // Negation copies bits up to and including the first 1, then inverts the rest.
    assign out_bit = (sign_q && seen) ? ~in_bit : in_bit;

    bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk           (clk),
        .rst           (rst),
        .clear         (accept),
        .count_enable  (state == SHIFT),
        .count         (cnt),
        .rollover_flag (last)
    );

    always_comb begin
        state_nxt = accept                     ? SHIFT :
                    (state == SHIFT && !last) ? SHIFT :
                    (state == SHIFT)          ? DONE  : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            overrun      <= 1'b0;
            mag_q        <= '0;
            sign_q       <= 1'b0;
            seen         <= 1'b0;
            sh           <= '0;
        end else begin
            state        <= state_nxt;
            busy         <= (state_nxt == SHIFT);
            result_valid <= (state_nxt == DONE);
            if (accept) begin
                mag_q   <= mag;
                sign_q  <= sign;
                seen    <= 1'b0;
                sh      <= '0;
                overrun <= 1'b0;
            end else if (state == SHIFT) begin
                sh   <= {out_bit, sh[WIDTH-1:1]};
                seen <= seen | in_bit;
                if (load)
                    overrun <= 1'b1;
                // Top bit only set when a 1 was seen, so -0 stays all-zero.
                if (last)
                    result <= {sign_q & (seen | in_bit), out_bit, sh[WIDTH-1:1]};
            end
        end
    end

endmodule
